// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the fetched-word record carried between
// the fetch stage and its hold buffer.
package mips_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam int          OPCODE_MSB       = 31;
  localparam int          OPCODE_LSB       = 26;
  localparam logic [5:0]  OP_RTYPE         = 6'b000000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_word_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks the word returning from memory while the
// pipeline is stalled. Clear has priority over load.
module fetch_hold_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        i_clr,
  input  logic        i_load,
  input  fetch_word_t i_word,
  output logic        o_valid,
  output fetch_word_t o_word
);

  logic        r_valid;
  fetch_word_t r_word;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_word  <= i_word;
    end
  end

  assign o_valid = r_valid;
  assign o_word  = r_word;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues reads to a synchronous
// instruction memory and fills the IF/ID register, with stall and redirect.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  ifid_opcode
);

  logic [31:0] r_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc4;
  logic        r_ifid_valid;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;

  logic        w_issue;
  logic [31:0] w_addr;
  logic [31:0] w_next_pc4;
  logic        w_hold_valid;
  logic        w_hold_clr;
  logic        w_hold_load;
  fetch_word_t w_hold_word;
  fetch_word_t w_ret_word;

  // A redirect always issues, even when hazard logic asks for a stall.
  assign w_issue    = !rst && (branch_taken || !stall);
  assign w_addr     = rst ? PC_RESET : (branch_taken ? branch_target : r_pc);
  assign w_next_pc4 = w_addr + 32'd4;

  assign w_ret_word = '{instr: imem_rdata, pc4: r_inflight_pc4};

  // The buffer drains on the first unstalled cycle; a wrong-path word dies here too.
  assign w_hold_clr  = rst || branch_taken || (!stall && w_hold_valid);
  assign w_hold_load = stall && r_inflight;

  fetch_hold_buf u_hold (
    .clk     (clk),
    .i_clr   (w_hold_clr),
    .i_load  (w_hold_load),
    .i_word  (w_ret_word),
    .o_valid (w_hold_valid),
    .o_word  (w_hold_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= PC_RESET;
      r_inflight     <= 1'b0;
      r_inflight_pc4 <= 32'd0;
      r_ifid_valid   <= 1'b0;
      r_ifid_instr   <= INSTR_NOP;
      r_ifid_pc4     <= 32'd0;
    end else begin
      if (w_issue) begin
        r_pc           <= w_next_pc4;
        r_inflight     <= 1'b1;
        r_inflight_pc4 <= w_next_pc4;
      end else begin
        r_inflight     <= 1'b0;
      end

      if (branch_taken) begin
        r_ifid_valid <= 1'b0;
      end else if (!stall) begin
        if (w_hold_valid) begin
          r_ifid_instr <= w_hold_word.instr;
          r_ifid_pc4   <= w_hold_word.pc4;
          r_ifid_valid <= 1'b1;
        end else if (r_inflight) begin
          r_ifid_instr <= imem_rdata;
          r_ifid_pc4   <= r_inflight_pc4;
          r_ifid_valid <= 1'b1;
        end else begin
          r_ifid_valid <= 1'b0;
        end
      end
    end
  end

  assign imem_addr   = w_addr;
  assign imem_rd_en  = w_issue;
  assign ifid_instr  = r_ifid_instr;
  assign ifid_pc4    = r_ifid_pc4;
  assign ifid_valid  = r_ifid_valid;
  assign ifid_opcode = r_ifid_instr[OPCODE_MSB:OPCODE_LSB];

endmodule
